// File: rtl/key_mode_ctrl.sv
// -----------------------------------------------------------------------------
// key_mode_ctrl
//   Front-panel key handling for the LCD pattern generator and status LEDs.
//   The raw, bouncy KEY pin is synchronised, debounced and classified as a
//   short or long press. A short press advances the display-mode index; a long
//   press toggles auto-cycling, which then advances the mode periodically.
//
//   Build option: define KEY_MODE_AUTO_EN to include long-press detection,
//   the AUTO flag and the auto-advance timer. Without it AUTO is tied low and
//   every debounced press advances the mode on its debounced release.
//
// Ports
//   CLK_SYS   in   system clock
//   nRST      in   asynchronous active-low reset
//   KEY       in   raw push-button, active-low, asynchronous
//   MODE      out  current display-mode index (quasi-static)
//   MODE_STB  out  one-cycle pulse in the cycle MODE takes a new value
//   AUTO      out  auto-cycling active
//   LED_R/G/B out  active-low status LEDs for modes 1/2/3, one cycle behind MODE
// -----------------------------------------------------------------------------
module key_mode_ctrl #(
    parameter int unsigned DEBOUNCE_CYC = 32'd2000000,
    parameter int unsigned LONG_CYC     = 32'd200000000,
    parameter int unsigned AUTO_CYC     = 32'd100000000,
    parameter int unsigned NUM_MODES    = 32'd4,
    parameter int unsigned MODE_W       = 32'd2
) (
    input  logic              CLK_SYS,
    input  logic              nRST,
    input  logic              KEY,
    output logic [MODE_W-1:0] MODE,
    output logic              MODE_STB,
    output logic              AUTO,
    output logic              LED_R,
    output logic              LED_G,
    output logic              LED_B
);

    localparam int unsigned DB_W = (DEBOUNCE_CYC > 32'd1) ? $clog2(DEBOUNCE_CYC) : 32'd1;
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYC - 32'd1);
    localparam logic [MODE_W-1:0] MODE_LAST = MODE_W'(NUM_MODES - 32'd1);

`ifdef KEY_MODE_AUTO_EN
    localparam int unsigned HOLD_W = (LONG_CYC > 32'd1) ? $clog2(LONG_CYC) : 32'd1;
    localparam int unsigned TMR_W  = (AUTO_CYC > 32'd1) ? $clog2(AUTO_CYC) : 32'd1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYC - 32'd1);
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(AUTO_CYC - 32'd1);
`endif

    // Reject configurations where MODE cannot hold every mode or a period is zero.
    if ((NUM_MODES > (32'd1 << MODE_W)) || (NUM_MODES == 32'd0) || (DEBOUNCE_CYC == 32'd0) ||
        (LONG_CYC == 32'd0) || (AUTO_CYC == 32'd0)) begin : g_cfg_err
        $error("key_mode_ctrl: invalid parameter set");
    end

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_DB_PRESS   = 3'd1,
        ST_PRESSED    = 3'd2,
        ST_DB_RELEASE = 3'd3
`ifdef KEY_MODE_AUTO_EN
        ,
        ST_LONG_HELD  = 3'd4
`endif
    } state_t;

    // Next mode index with wrap to zero after the last mode.
    function automatic logic [MODE_W-1:0] f_mode_next(input logic [MODE_W-1:0] m);
        if (m >= MODE_LAST) begin
            f_mode_next = '0;
        end else begin
            f_mode_next = m + MODE_W'(1);
        end
    endfunction

    // Active-low {R,G,B} decode; mode 0 and modes above 3 light nothing.
    function automatic logic [2:0] f_led(input logic [MODE_W-1:0] m);
        case (32'(m))
            32'd1:   f_led = 3'b011;
            32'd2:   f_led = 3'b101;
            32'd3:   f_led = 3'b110;
            default: f_led = 3'b111;
        endcase
    endfunction

    logic              key_meta_q;
    logic              key_s_q;
    state_t            state_q, state_d;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic              press_adv_s;
    logic              adv_s;
    logic [MODE_W-1:0] mode_q, mode_d;
    logic              stb_q, stb_d;
    logic [2:0]        led_q, led_d;
`ifdef KEY_MODE_AUTO_EN
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              origin_long_q, origin_long_d;
    logic              auto_tgl_s;
    logic              auto_fire_s;
    logic              auto_q, auto_d;
    logic [TMR_W-1:0]  auto_cnt_q, auto_cnt_d;
`endif

    // Two-flop synchroniser for the asynchronous key; idles released (high).
    always_ff @(posedge CLK_SYS or negedge nRST) begin
        if (!nRST) begin
            key_meta_q <= 1'b1;
            key_s_q    <= 1'b1;
        end else begin
            key_meta_q <= KEY;
            key_s_q    <= key_meta_q;
        end
    end

    // Press FSM next-state: debounce both edges, classify short/long.
    always_comb begin
        state_d       = state_q;
        db_cnt_d      = db_cnt_q;
        press_adv_s   = 1'b0;
`ifdef KEY_MODE_AUTO_EN
        hold_cnt_d    = hold_cnt_q;
        origin_long_d = origin_long_q;
        auto_tgl_s    = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!key_s_q) begin
                    state_d  = ST_DB_PRESS;
                    db_cnt_d = '0;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_DB_PRESS: begin
                if (key_s_q) begin
                    state_d = ST_IDLE;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d = ST_PRESSED;
`ifdef KEY_MODE_AUTO_EN
                    hold_cnt_d = '0;
`endif
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end
            ST_PRESSED: begin
                if (key_s_q) begin
                    state_d  = ST_DB_RELEASE;
                    db_cnt_d = '0;
`ifdef KEY_MODE_AUTO_EN
                    origin_long_d = 1'b0;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d    = ST_LONG_HELD;
                    auto_tgl_s = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
`else
                end else begin
                    state_d = ST_PRESSED;
                end
`endif
            end
`ifdef KEY_MODE_AUTO_EN
            ST_LONG_HELD: begin
                // No auto-repeat while held; only the release matters here.
                if (key_s_q) begin
                    state_d       = ST_DB_RELEASE;
                    db_cnt_d      = '0;
                    origin_long_d = 1'b1;
                end else begin
                    state_d = ST_LONG_HELD;
                end
            end
`endif
            ST_DB_RELEASE: begin
                if (!key_s_q) begin
                    // Release bounce: resume where we came from, hold count kept.
`ifdef KEY_MODE_AUTO_EN
                    state_d = origin_long_q ? ST_LONG_HELD : ST_PRESSED;
`else
                    state_d = ST_PRESSED;
`endif
                    db_cnt_d = '0;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d = ST_IDLE;
`ifdef KEY_MODE_AUTO_EN
                    press_adv_s = ~origin_long_q;
`else
                    press_adv_s = 1'b1;
`endif
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Mode advance, auto timer and LED decode next-state.
    always_comb begin
        mode_d = mode_q;
        stb_d  = 1'b0;
        led_d  = f_led(mode_q);
`ifdef KEY_MODE_AUTO_EN
        auto_d      = auto_q ^ auto_tgl_s;
        auto_fire_s = auto_q && (auto_cnt_q == TMR_LAST);
        // A press release landing on the auto expiry merges into one advance.
        adv_s       = press_adv_s | auto_fire_s;
        if (auto_tgl_s || adv_s) begin
            auto_cnt_d = '0;
        end else if (auto_q) begin
            auto_cnt_d = auto_cnt_q + TMR_W'(1);
        end else begin
            auto_cnt_d = auto_cnt_q;
        end
`else
        adv_s = press_adv_s;
`endif
        if (adv_s) begin
            mode_d = f_mode_next(mode_q);
            stb_d  = 1'b1;
        end else begin
            mode_d = mode_q;
            stb_d  = 1'b0;
        end
    end

    // FSM and counter registers.
    always_ff @(posedge CLK_SYS or negedge nRST) begin
        if (!nRST) begin
            state_q       <= ST_IDLE;
            db_cnt_q      <= '0;
`ifdef KEY_MODE_AUTO_EN
            hold_cnt_q    <= '0;
            origin_long_q <= 1'b0;
            auto_q        <= 1'b0;
            auto_cnt_q    <= '0;
`endif
        end else begin
            state_q       <= state_d;
            db_cnt_q      <= db_cnt_d;
`ifdef KEY_MODE_AUTO_EN
            hold_cnt_q    <= hold_cnt_d;
            origin_long_q <= origin_long_d;
            auto_q        <= auto_d;
            auto_cnt_q    <= auto_cnt_d;
`endif
        end
    end

    // Registered outputs: mode, strobe and LEDs.
    always_ff @(posedge CLK_SYS or negedge nRST) begin
        if (!nRST) begin
            mode_q <= '0;
            stb_q  <= 1'b0;
            led_q  <= 3'b111;
        end else begin
            mode_q <= mode_d;
            stb_q  <= stb_d;
            led_q  <= led_d;
        end
    end

    assign MODE     = mode_q;
    assign MODE_STB = stb_q;
    assign LED_R    = led_q[2];
    assign LED_G    = led_q[1];
    assign LED_B    = led_q[0];
`ifdef KEY_MODE_AUTO_EN
    assign AUTO     = auto_q;
`else
    assign AUTO     = 1'b0;
`endif

endmodule

// File: tb/tb_key_mode_ctrl.sv
// -----------------------------------------------------------------------------
// tb_key_mode_ctrl
//   Self-checking bench for key_mode_ctrl with short periods. A cycle-level
//   reference model built from run lengths of the synchronised key and a
//   timestamp for the next auto advance predicts every output each cycle;
//   directed phases add latency, period and wrap checks, then randomized
//   press / bounce / reset traffic follows.
// -----------------------------------------------------------------------------
module tb_key_mode_ctrl;

    localparam int DEB = 16;
    localparam int LNG = 256;
    localparam int AUT = 64;
    localparam int NM  = 4;
    localparam int MW  = 2;

    logic          clk_sys_s = 1'b0;
    logic          nrst_s    = 1'b0;
    logic          key_s     = 1'b1;
    logic [MW-1:0] mode_s;
    logic          mode_stb_s, auto_s, led_r_s, led_g_s, led_b_s;

    int total_s = 0;
    int bad_s   = 0;
    int now_s   = 0;
    int stb_t_s[$];

    // Reference model state.
    logic       m_meta, m_ks, m_down, m_long, m_stb, m_auto;
    int         m_pend, m_hold, m_next, m_cyc;
    logic [1:0] m_mode;
    logic [2:0] m_led;

    key_mode_ctrl #(
        .DEBOUNCE_CYC(32'd16),
        .LONG_CYC    (32'd256),
        .AUTO_CYC    (32'd64),
        .NUM_MODES   (32'd4),
        .MODE_W      (32'd2)
    ) u_dut (
        .CLK_SYS (clk_sys_s),
        .nRST    (nrst_s),
        .KEY     (key_s),
        .MODE    (mode_s),
        .MODE_STB(mode_stb_s),
        .AUTO    (auto_s),
        .LED_R   (led_r_s),
        .LED_G   (led_g_s),
        .LED_B   (led_b_s)
    );

    // 100 MHz-style bench clock; absolute period is irrelevant to the design.
    always #5 clk_sys_s = ~clk_sys_s;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total_s++;
        if (got !== want) begin
            bad_s++;
            if (bad_s <= 30) $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, got, want, now_s);
        end
    endtask

    function automatic logic [31:0] dut_outs();
        return {25'd0, mode_s, mode_stb_s, auto_s, led_r_s, led_g_s, led_b_s};
    endfunction

    function automatic logic [31:0] mdl_outs();
        return {25'd0, m_mode, m_stb, m_auto, m_led};
    endfunction

    task automatic model_reset();
        m_meta = 1'b1; m_ks = 1'b1; m_down = 1'b0; m_long = 1'b0;
        m_pend = 0; m_hold = 0; m_next = 0;
        m_mode = 2'd0; m_stb = 1'b0; m_auto = 1'b0; m_led = 3'b111;
    endtask

    // One clock edge of the model. A level change of the synchronised key is
    // accepted after DEB+1 consecutive samples at the new level (the sample
    // that notices it plus the debounce run). Hold time counts only samples
    // taken while the press is steady.
    task automatic model_step(input logic k);
        logic ks, adv_press, fire, adv, toggle;
        ks = m_ks;
        m_ks = m_meta;
        m_meta = k;
        adv_press = 1'b0;
        toggle = 1'b0;
        if (!m_down) begin
            if (!ks) begin
                m_pend++;
                if (m_pend == DEB + 1) begin
                    m_down = 1'b1; m_pend = 0; m_hold = 0; m_long = 1'b0;
                end
            end else begin
                m_pend = 0;
            end
        end else begin
            if (ks) begin
                m_pend++;
                if (m_pend == DEB + 1) begin
                    m_down = 1'b0; m_pend = 0; adv_press = !m_long;
                end
            end else begin
`ifdef KEY_MODE_AUTO_EN
                if (m_pend == 0 && !m_long) begin
                    if (m_hold == LNG - 1) begin
                        m_long = 1'b1; toggle = 1'b1;
                    end else begin
                        m_hold++;
                    end
                end
`endif
                m_pend = 0;
            end
        end
        fire = m_auto && (m_cyc == m_next);
        adv = adv_press || fire;
        m_led = {m_mode != 2'd1, m_mode != 2'd2, m_mode != 2'd3};
        if (adv) m_mode = 2'((int'(m_mode) + 1) % NM);
        m_stb = adv;
        if (toggle) m_auto = !m_auto;
        if (toggle || adv) m_next = m_cyc + AUT;
        m_cyc++;
    endtask

    // Advance one clock, update the model and compare all outputs.
    task automatic tick();
        @(negedge clk_sys_s);
        if (!nrst_s) model_reset();
        else model_step(key_s);
        now_s++;
        chk("outs", dut_outs(), mdl_outs());
        if (mode_stb_s) stb_t_s.push_back(now_s);
    endtask

    task automatic hold(input logic lvl, input int n);
        key_s = lvl;
        repeat (n) tick();
    endtask

    int s0, r0, f0, t_auto, lat, s_ref, ok, n, first_t, second_t;
    int tl[$];

    initial begin
        m_cyc = 0;
        model_reset();

        // Reset with key released.
        key_s = 1'b1;
        nrst_s = 1'b0;
        tick();
        chk("rst_vals", dut_outs(), 32'h07);
        repeat (4) tick();
        nrst_s = 1'b1;
        s0 = stb_t_s.size();
        repeat (100) tick();
        chk("idle_stb", 32'(stb_t_s.size() - s0), 32'd0);
        chk("idle_vals", dut_outs(), 32'h07);

        // One clean short press.
        hold(1'b0, 100);
        r0 = now_s;
        s0 = stb_t_s.size();
        hold(1'b1, 100);
        chk("press_stb", 32'(stb_t_s.size() - s0), 32'd1);
        lat = (stb_t_s.size() > s0) ? stb_t_s[s0] - r0 : -1;
        chk("press_lat_win", 32'((lat >= 2 + DEB - 1) && (lat <= 2 + DEB + 1)), 32'd1);
        chk("press_mode", 32'(mode_s), 32'd1);
        chk("press_led_r", 32'(led_r_s), 32'd0);

        // Bounce shorter than the debounce run is ignored.
        s0 = stb_t_s.size();
        for (int i = 0; i < 40; i++) hold(~key_s, 5);
        hold(1'b1, 100);
        chk("bounce_stb", 32'(stb_t_s.size() - s0), 32'd0);
        chk("bounce_mode", 32'(mode_s), 32'd1);

        // Walk to mode 3, then four presses wrap through 0,1,2,3.
        hold(1'b0, 40); hold(1'b1, 40);
        hold(1'b0, 40); hold(1'b1, 40);
        chk("pre_wrap_mode", 32'(mode_s), 32'd3);
        s0 = stb_t_s.size();
        for (int i = 0; i < 4; i++) begin
            hold(1'b0, 40);
            hold(1'b1, 40);
            chk("wrap_seq", 32'(mode_s), 32'(i));
        end
        chk("wrap_stb", 32'(stb_t_s.size() - s0), 32'd4);

        // Long press.
        f0 = now_s;
        t_auto = -1;
        s0 = stb_t_s.size();
        key_s = 1'b0;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (auto_s && t_auto < 0) t_auto = now_s;
        end
        hold(1'b1, 300);
`ifdef KEY_MODE_AUTO_EN
        chk("auto_rise_win", 32'((t_auto - f0 >= 272) && (t_auto - f0 <= 277)), 32'd1);
        chk("auto_on", 32'(auto_s), 32'd1);
        tl.delete();
        for (int i = s0; i < stb_t_s.size(); i++) tl.push_back(stb_t_s[i]);
        ok = 1;
        foreach (tl[i]) if (t_auto < 0 || tl[i] <= t_auto || (tl[i] - t_auto) % AUT != 0) ok = 0;
        chk("auto_grid", 32'(ok), 32'd1);
        chk("auto_cnt", 32'(tl.size()), (t_auto < 0) ? 32'd0 : 32'((now_s - t_auto) / AUT));
        if (tl.size() >= 2) chk("auto_period", 32'(tl[1] - tl[0]), 32'(AUT));

        // Short-press release timed onto the auto expiry.
        s_ref = -1;
        for (int i = 0; i < 100 && s_ref < 0; i++) begin
            tick();
            if (mode_stb_s) s_ref = now_s;
        end
        chk("coin_found", 32'(s_ref >= 0), 32'd1);
        if (s_ref < 0) s_ref = now_s;
        s0 = stb_t_s.size();
        key_s = 1'b0;
        while (now_s < s_ref + AUT - (2 + 1 + DEB)) tick();
        hold(1'b1, 140);
        n = 0; first_t = -1; second_t = -1;
        for (int i = s0; i < stb_t_s.size(); i++) begin
            n++;
            if (n == 1) first_t = stb_t_s[i];
            if (n == 2) second_t = stb_t_s[i];
        end
        chk("coin_cnt", 32'(n), 32'd2);
        chk("coin_t1", 32'(first_t - s_ref), 32'(AUT));
        chk("coin_t2", 32'(second_t - s_ref), 32'(2 * AUT));
`else
        chk("auto_tied", 32'(auto_s), 32'd0);
        chk("long_adv", 32'(stb_t_s.size() - s0), 32'd1);
`endif

        // Reset asserted mid-hold, key still held afterwards.
        hold(1'b0, 100);
        nrst_s = 1'b0;
        #1;
        chk("rst_mid", dut_outs(), 32'h07);
        repeat (3) tick();
        nrst_s = 1'b1;
        hold(1'b0, 60);
        hold(1'b1, 60);
        chk("rst_repress", 32'(mode_s), 32'd1);

        // Randomized traffic.
        for (int op = 0; op < 40; op++) begin
            case ($urandom_range(0, 5))
                0: begin
                    hold(1'b0, $urandom_range(1, 240));
                    hold(1'b1, $urandom_range(1, 80));
                end
                1: begin
                    hold(1'b0, $urandom_range(260, 480));
                    hold(1'b1, $urandom_range(20, 80));
                end
                2: begin
                    repeat ($urandom_range(2, 10)) begin
                        hold(1'b0, $urandom_range(1, 20));
                        hold(1'b1, $urandom_range(1, 20));
                    end
                    hold(1'b1, 30);
                end
                3: begin
                    hold(1'b0, $urandom_range(30, 200));
                    repeat ($urandom_range(1, 6)) begin
                        hold(1'b1, $urandom_range(1, 18));
                        hold(1'b0, $urandom_range(1, 18));
                    end
                    hold(1'b1, 40);
                end
                4: begin
                    hold(1'b1, $urandom_range(1, 300));
                end
                default: begin
                    nrst_s = 1'b0;
                    repeat ($urandom_range(1, 4)) tick();
                    nrst_s = 1'b1;
                end
            endcase
        end
        hold(1'b1, 50);

        $display("test done: total=%0d bad=%0d", total_s, bad_s);
        $finish;
    end

endmodule
